// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and state encodings for the sequential ALU.
// Imported by the top level and the iterative multiply/divide unit.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;
   localparam logic [3:0] ALU_MUL = 4'h4;
   localparam logic [3:0] ALU_DIV = 4'h5;
   localparam logic [3:0] ALU_SAL = 4'h6;
   localparam logic [3:0] ALU_SAR = 4'h7;
   localparam logic [3:0] ALU_OR  = 4'h8;
   localparam logic [3:0] ALU_NOT = 4'h9;
   localparam logic [3:0] ALU_MOD = 4'hA;

   localparam int FLG_OF = 0;
   localparam int FLG_SF = 1;
   localparam int FLG_ZF = 2;
   localparam int FLG_DZ = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      MD_MUL = 1'b0,
      MD_DIV = 1'b1
   } md_op_t;

endpackage

// File: rtl/alu_seq_if.sv
// Issue-side and writeback-side valid/ready handshake bundle of the sequential ALU.
// master = producer/consumer around the ALU, slave = the ALU itself.
interface alu_seq_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] val_a;
   logic [W-1:0] val_b;
   logic [3:0]   fun;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, val_a, val_b, fun, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, val_a, val_b, fun, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned magnitude engine: W-step shift-add multiply or restoring divide.
// Outputs show the value after the current step, so they are final while done is high.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           start,
   input  md_op_t         op,
   input  logic [W-1:0]   a_mag,
   input  logic [W-1:0]   b_mag,
   output logic           done,
   output logic [2*W-1:0] product,
   output logic [W-1:0]   quotient,
   output logic [W-1:0]   remainder
);
   localparam int CW = $clog2(W);

   // hi = accumulator / partial remainder, lo = multiplier / dividend shifting out
   logic [W-1:0]  r_hi;
   logic [W-1:0]  r_lo;
   logic [W-1:0]  r_opnd;
   md_op_t        r_op;
   logic [CW-1:0] r_count;
   logic          r_busy;

   logic [W:0]    w_sum;
   logic [W:0]    w_trial;
   logic [W-1:0]  w_hi_next;
   logic [W-1:0]  w_lo_next;

   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
      w_trial = {r_hi, r_lo[W-1]} - {1'b0, r_opnd};
      if (r_op == MD_MUL) begin
         w_hi_next = w_sum[W:1];
         w_lo_next = {w_sum[0], r_lo[W-1:1]};
      end else if (!w_trial[W]) begin
         w_hi_next = w_trial[W-1:0];
         w_lo_next = {r_lo[W-2:0], 1'b1};
      end else begin
         w_hi_next = {r_hi[W-2:0], r_lo[W-1]};
         w_lo_next = {r_lo[W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hi    <= '0;
         r_lo    <= '0;
         r_opnd  <= '0;
         r_op    <= MD_MUL;
         r_count <= '0;
         r_busy  <= 1'b0;
      end else if (start) begin
         r_hi    <= '0;
         r_lo    <= b_mag;
         r_opnd  <= a_mag;
         r_op    <= op;
         r_count <= CW'(W - 1);
         r_busy  <= 1'b1;
      end else if (r_busy) begin
         r_hi <= w_hi_next;
         r_lo <= w_lo_next;
         if (r_count == '0) begin
            r_busy <= 1'b0;
         end else begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign done      = r_busy & (r_count == '0);
   assign product   = {w_hi_next, w_lo_next};
   assign quotient  = w_lo_next;
   assign remainder = w_hi_next;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute ALU: single-cycle ops finish in one cycle, MUL/DIV/MOD iterate
// on magnitudes in alu_muldiv_iter; sign fixup, flags and handshake live here.
module alu_seq
   import alu_pkg::*;
#(
   parameter int W        = 32,
   parameter int MUL_ITER = 1
) (
   input  logic     clock,
   input  logic     reset_n,
   alu_seq_if.slave bus
);
   localparam int SW = $clog2(W);

   state_t         r_state;
   logic [W-1:0]   r_result;
   logic [3:0]     r_flags;
   logic           r_out_valid;
   logic [3:0]     r_fun;
   logic           r_neg_pq;
   logic           r_neg_b;

   logic           w_accept;
   logic           w_iter;
   logic [W-1:0]   w_a_mag;
   logic [W-1:0]   w_b_mag;
   logic [2*W-1:0] w_sc_prod;
   logic [W-1:0]   w_sc_result;
   logic           w_sc_of;
   logic           w_sc_dz;
   md_op_t         w_md_op;
   logic           w_md_done;
   logic [2*W-1:0] w_md_product;
   logic [W-1:0]   w_md_quotient;
   logic [W-1:0]   w_md_remainder;
   logic [2*W-1:0] w_prod_s;
   logic [W-1:0]   w_it_result;
   logic           w_it_of;

   // overflow when the upper W+1 bits of the 2W product are not a pure sign extension
   function automatic logic prod_ovf(input logic [2*W-1:0] p);
      return ~((&p[2*W-1:W-1]) | ~(|p[2*W-1:W-1]));
   endfunction

   function automatic logic [3:0] pack_flags(input logic [W-1:0] res, input logic of,
                                             input logic dz);
      logic [3:0] f;
      f         = '0;
      f[FLG_OF] = of;
      f[FLG_SF] = res[W-1];
      f[FLG_ZF] = (res == '0);
      f[FLG_DZ] = dz;
      return f;
   endfunction

   assign bus.in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & bus.out_ready);
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.flags     = r_flags;

   assign w_accept = bus.in_valid & bus.in_ready;
   // divide by zero never enters BUSY; it is answered in one cycle with DZ set
   assign w_iter   = (((bus.fun == ALU_DIV) | (bus.fun == ALU_MOD)) & (bus.val_a != '0))
                   | ((bus.fun == ALU_MUL) & (MUL_ITER != 0));
   assign w_a_mag  = bus.val_a[W-1] ? -bus.val_a : bus.val_a;
   assign w_b_mag  = bus.val_b[W-1] ? -bus.val_b : bus.val_b;
   assign w_md_op  = (bus.fun == ALU_MUL) ? MD_MUL : MD_DIV;
   assign w_sc_prod = {{W{bus.val_b[W-1]}}, bus.val_b} * {{W{bus.val_a[W-1]}}, bus.val_a};

   always_comb begin
      w_sc_result = bus.val_b;
      w_sc_of     = 1'b0;
      w_sc_dz     = 1'b0;
      case (bus.fun)
         ALU_ADD: begin
            w_sc_result = bus.val_b + bus.val_a;
            w_sc_of     = (bus.val_a[W-1] == bus.val_b[W-1]) & (w_sc_result[W-1] != bus.val_b[W-1]);
         end
         ALU_SUB: begin
            w_sc_result = bus.val_b - bus.val_a;
            w_sc_of     = (bus.val_a[W-1] != bus.val_b[W-1]) & (w_sc_result[W-1] != bus.val_b[W-1]);
         end
         ALU_AND: w_sc_result = bus.val_b & bus.val_a;
         ALU_XOR: w_sc_result = bus.val_b ^ bus.val_a;
         ALU_OR:  w_sc_result = bus.val_b | bus.val_a;
         ALU_NOT: w_sc_result = ~bus.val_b;
         ALU_SAL: w_sc_result = bus.val_b << bus.val_a[SW-1:0];
         ALU_SAR: w_sc_result = W'($signed(bus.val_b) >>> bus.val_a[SW-1:0]);
         ALU_MUL: begin
            w_sc_result = w_sc_prod[W-1:0];
            w_sc_of     = prod_ovf(w_sc_prod);
         end
         ALU_DIV: begin
            w_sc_result = '1;
            w_sc_dz     = 1'b1;
         end
         ALU_MOD: begin
            w_sc_result = bus.val_b;
            w_sc_dz     = 1'b1;
         end
         default: w_sc_result = bus.val_b;
      endcase
   end

   alu_muldiv_iter #(.W(W)) u_muldiv (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (w_accept & w_iter),
      .op        (w_md_op),
      .a_mag     (w_a_mag),
      .b_mag     (w_b_mag),
      .done      (w_md_done),
      .product   (w_md_product),
      .quotient  (w_md_quotient),
      .remainder (w_md_remainder)
   );

   // quotient magnitude 2^(W-1) with a positive sign is only reachable as MIN / -1
   assign w_prod_s = r_neg_pq ? -w_md_product : w_md_product;
   always_comb begin
      w_it_result = '0;
      w_it_of     = 1'b0;
      case (r_fun)
         ALU_MUL: begin
            w_it_result = w_prod_s[W-1:0];
            w_it_of     = prod_ovf(w_prod_s);
         end
         ALU_DIV: begin
            w_it_result = r_neg_pq ? -w_md_quotient : w_md_quotient;
            w_it_of     = ~r_neg_pq & w_md_quotient[W-1];
         end
         default: w_it_result = r_neg_b ? -w_md_remainder : w_md_remainder;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_result    <= '0;
         r_flags     <= '0;
         r_out_valid <= 1'b0;
         r_fun       <= ALU_ADD;
         r_neg_pq    <= 1'b0;
         r_neg_b     <= 1'b0;
      end else if (w_accept) begin
         r_fun    <= bus.fun;
         r_neg_pq <= bus.val_a[W-1] ^ bus.val_b[W-1];
         r_neg_b  <= bus.val_b[W-1];
         if (w_iter) begin
            r_state     <= ST_BUSY;
            r_out_valid <= 1'b0;
         end else begin
            r_state     <= ST_DONE;
            r_result    <= w_sc_result;
            r_flags     <= pack_flags(w_sc_result, w_sc_of, w_sc_dz);
            r_out_valid <= 1'b1;
         end
      end else begin
         case (r_state)
            ST_IDLE: ;
            ST_BUSY: begin
               if (w_md_done) begin
                  r_state     <= ST_DONE;
                  r_result    <= w_it_result;
                  r_flags     <= pack_flags(w_it_result, w_it_of, 1'b0);
                  r_out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=32, iterative MUL): stimulus pushes expected results into
// a queue, a negedge monitor pops and compares every result the ALU hands over.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_seq_if #(.W(W)) bus ();

   alu_seq #(.W(W), .MUL_ITER(1)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      string        name;
      logic [W-1:0] res;
      logic [3:0]   flg;
      int           lat;
      int           acc_cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // monitor: every handed-over result must match the oldest outstanding expectation
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got result 0x%08h with nothing outstanding", bus.result);
            end else begin
               mon_e = exp_q.pop_front();
               check({mon_e.name, " result"}, bus.result, mon_e.res);
               check({mon_e.name, " flags"}, W'(bus.flags), W'(mon_e.flg));
               if (mon_e.lat >= 0)
                  check({mon_e.name, " latency"}, W'(cyc - mon_e.acc_cyc), W'(mon_e.lat));
               $display("txn %-12s result=0x%08h flags=%04b latency=%0d", mon_e.name,
                        bus.result, bus.flags, cyc - mon_e.acc_cyc);
            end
         end
      end
   end

   task automatic send(input string name, input logic [3:0] f, input logic [W-1:0] b,
                       input logic [W-1:0] a, input logic [W-1:0] er, input logic [3:0] ef,
                       input int lat, output int waited);
      exp_t e;
      bit   ok;
      ok           = 1'b0;
      waited       = 0;
      bus.in_valid = 1'b1;
      bus.fun      = f;
      bus.val_b    = b;
      bus.val_a    = a;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         else waited++;
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s accept_timeout: in_ready stayed 0, expected 1 within 200 cycles", name);
      end else begin
         e.name    = name;
         e.res     = er;
         e.flg     = ef;
         e.lat     = lat;
         e.acc_cyc = cyc;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_b2b(input string name, input logic [3:0] f, input logic [W-1:0] b,
                           input logic [W-1:0] a, input logic [W-1:0] er, input logic [3:0] ef);
      int w;
      send(name, f, b, a, er, ef, 1, w);
      check({name, " ready_wait"}, W'(w), '0);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s drain_timeout: %0d results outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      #1;
   endtask

   initial begin
      int w;
      bus.in_valid  = 1'b0;
      bus.fun       = ALU_ADD;
      bus.val_a     = '0;
      bus.val_b     = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", W'(bus.out_valid), '0);
      check("reset result", bus.result, '0);
      check("reset flags", W'(bus.flags), '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset in_ready", W'(bus.in_ready), W'(1));
      @(posedge clk);
      #1;

      // single-cycle ops issued every cycle: in_ready must never drop
      send_b2b("add_ovf",  ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0011);
      send_b2b("add_zero", ALU_ADD, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 4'b0100);
      send_b2b("add_negov",ALU_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0101);
      send_b2b("sub_ovf",  ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001);
      send_b2b("and",      ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000);
      send_b2b("xor",      ALU_XOR, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'b0010);
      send_b2b("or",       ALU_OR,  32'h0000_0001, 32'h8000_0000, 32'h8000_0001, 4'b0010);
      send_b2b("not",      ALU_NOT, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 4'b0100);
      send_b2b("sal",      ALU_SAL, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 4'b0000);
      send_b2b("pass",     4'hF,    32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 4'b0000);
      send_b2b("div_by0",  ALU_DIV, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1010);
      send_b2b("mod_by0",  ALU_MOD, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 4'b1000);
      drain("single");

      // iterative ops: W+1 cycles from acceptance to out_valid
      send("div_m7_2",  ALU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 4'b0010, 33, w);
      send("mod_m7_2",  ALU_MOD, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 4'b0010, 33, w);
      send("div_minm1", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0011, 33, w);
      send("mod_minm1", ALU_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100, 33, w);
      send("div_100_m7",ALU_DIV, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 4'b0010, 33, w);
      send("mod_100_m7",ALU_MOD, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 4'b0000, 33, w);
      send("mul_ovf",   ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0101, 33, w);
      send("mul_m3_4",  ALU_MUL, 32'hFFFF_FFFD, 32'h0000_0004, 32'hFFFF_FFF4, 4'b0010, 33, w);
      drain("iter");

      // back-pressure: result held, then drained in the same cycle a new op is accepted
      bus.out_ready = 1'b0;
      send("sar", ALU_SAR, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4'b0010, -1, w);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold out_valid", W'(bus.out_valid), W'(1));
         check("hold result", bus.result, 32'hF800_0000);
         check("hold flags", W'(bus.flags), W'(4'b0010));
         check("hold in_ready", W'(bus.in_ready), '0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send_b2b("add_after_hold", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0011);
      drain("hold");

      // reset in the middle of a divide discards it
      send("div_reset", ALU_DIV, 32'h0000_03E8, 32'h0000_0003, 32'h0000_014D, 4'b0000, 33, w);
      repeat (9) @(posedge clk);
      #1;
      check("busy in_ready", W'(bus.in_ready), '0);
      rst_n = 1'b0;
      #1;
      check("midreset out_valid", W'(bus.out_valid), '0);
      check("midreset result", bus.result, '0);
      check("midreset flags", W'(bus.flags), '0);
      exp_q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("postreset in_ready", W'(bus.in_ready), W'(1));
      repeat (40) @(posedge clk);
      #1;
      send("add_2_3", ALU_ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 4'b0000, 1, w);
      drain("final");

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
